// File: rtl/comparator_seq.sv
// comparator_seq: sequential MSB-first magnitude comparator.
// Walks two WIDTH-bit operands DIGIT bits per clock and stops at the first
// differing digit. Signed mode flips both sign bits at capture, so the
// unsigned digit walk yields two's-complement order.
//
// Handshake: start is sampled only while idle (busy=0). The accepting edge
// raises busy and clears gto/lto/eqo. The deciding edge drops busy and
// raises done for exactly one cycle. The result flags hold until the next
// accepted start.
module comparator_seq #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  output logic             busy,
  output logic             done,
  output logic             gto,
  output logic             lto,
  output logic             eqo,
  output logic             dbg_state_o
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    LAST_DIGIT = CW'(N - 1);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_COMPARE = 1'b1
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q, gto_q, lto_q, eqo_q;

  // Current digit under test: the top DIGIT bits of each shift register.
  logic [DIGIT-1:0] a_top, b_top;
  assign a_top = a_q[WIDTH-1 -: DIGIT];
  assign b_top = b_q[WIDTH-1 -: DIGIT];

  // Control FSM with registered handshake and result flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gto_q   <= 1'b0;
      lto_q   <= 1'b0;
      eqo_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= signed_mode ? (num1 ^ MSB_MASK) : num1;
            b_q     <= signed_mode ? (num2 ^ MSB_MASK) : num2;
            cnt_q   <= '0;
            gto_q   <= 1'b0;
            lto_q   <= 1'b0;
            eqo_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          if (a_top > b_top) begin
            gto_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else if (a_top < b_top) begin
            lto_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else if (cnt_q == LAST_DIGIT) begin
            eqo_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            a_q   <= a_q << DIGIT;
            b_q   <= b_q << DIGIT;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign gto         = gto_q;
  assign lto         = lto_q;
  assign eqo         = eqo_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_comparator_seq.sv
// Bench for comparator_seq: directed scenarios on a DIGIT=4 instance plus a
// random sweep across DIGIT=1/4/16 instances against a reference model.
module tb_comparator_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        signed_mode;
  logic [15:0] num1, num2;

  logic busy1, done1, gto1, lto1, eqo1, st1;
  logic busy4, done4, gto4, lto4, eqo4, st4;
  logic busy16, done16, gto16, lto16, eqo16, st16;

  int total;
  int bad;

  comparator_seq #(.WIDTH(16), .DIGIT(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .num1(num1), .num2(num2), .busy(busy4), .done(done4),
    .gto(gto4), .lto(lto4), .eqo(eqo4), .dbg_state_o(st4)
  );

  comparator_seq #(.WIDTH(16), .DIGIT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .num1(num1), .num2(num2), .busy(busy1), .done(done1),
    .gto(gto1), .lto(lto1), .eqo(eqo1), .dbg_state_o(st1)
  );

  comparator_seq #(.WIDTH(16), .DIGIT(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
    .num1(num1), .num2(num2), .busy(busy16), .done(done16),
    .gto(gto16), .lto(lto16), .eqo(eqo16), .dbg_state_o(st16)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: order by plain integer comparison.
  function automatic logic [2:0] model_res(input logic [15:0] a, input logic [15:0] b,
                                           input logic sm);
    int ia, ib;
    if (sm) begin
      ia = int'($signed(a));
      ib = int'($signed(b));
    end else begin
      ia = int'(a);
      ib = int'(b);
    end
    if (ia > ib) return 3'b100;
    if (ia < ib) return 3'b010;
    return 3'b001;
  endfunction

  // Reference model: 1-based index of the first differing digit, or N if equal.
  // Flipping both sign bits leaves the difference pattern unchanged.
  function automatic int model_lat(input logic [15:0] a, input logic [15:0] b, input int d);
    int n;
    int x;
    n = 16 / d;
    x = int'(a ^ b);
    for (int k = 1; k <= n; k++) begin
      if (((x >> (16 - k * d)) & ((1 << d) - 1)) != 0) return k;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: one comparison on the DIGIT=4 instance, with full handshake checks.
  task automatic do_cmp(input logic [15:0] a, input logic [15:0] b, input logic sm,
                        input string tag);
    int lat;
    lat = 0;
    num1 = a; num2 = b; signed_mode = sm; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy4), 32'd1);
    chk({tag, "_clr"}, 32'({gto4, lto4, eqo4}), 32'd0);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (done4) begin
        lat = c;
        break;
      end
    end
    chk({tag, "_lat"}, 32'(lat), 32'(model_lat(a, b, 4)));
    chk({tag, "_res"}, 32'({gto4, lto4, eqo4}), 32'(model_res(a, b, sm)));
    chk({tag, "_busy_at_done"}, 32'(busy4), 32'd0);
    @(negedge clk);
    chk({tag, "_done_width"}, 32'(done4), 32'd0);
    chk({tag, "_held"}, 32'({gto4, lto4, eqo4}), 32'(model_res(a, b, sm)));
  endtask

  initial begin
    int lat;
    int dcnt;
    total = 0;
    bad = 0;
    rst_n = 1'b0; start = 1'b0; signed_mode = 1'b0; num1 = '0; num2 = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_outs", 32'({busy4, done4, gto4, lto4, eqo4, st4}), 32'd0);

    // Directed unsigned and signed cases.
    do_cmp(16'h1234, 16'h1234, 1'b0, "eq_1234");
    do_cmp(16'hA000, 16'h9FFF, 1'b0, "gt_first");
    do_cmp(16'h12A0, 16'h12B0, 1'b0, "lt_third");
    do_cmp(16'h8000, 16'h0001, 1'b1, "signed_neg");
    do_cmp(16'h8000, 16'h0001, 1'b0, "unsigned_big");
    do_cmp(16'hFFFF, 16'hFFFE, 1'b1, "signed_ffff");
    chk("eq_1234_lat_const", 32'(model_lat(16'h1234, 16'h1234, 4)), 32'd4);

    // start and operand changes while busy are ignored.
    num1 = 16'h1234; num2 = 16'h1235; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    num1 = 16'hFFFF; num2 = 16'h0000; signed_mode = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 2;
    while (!done4 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chk("busy_ignore_lat", 32'(lat), 32'd4);
    chk("busy_ignore_res", 32'({gto4, lto4, eqo4}), 32'b010);

    // Back-to-back: start held in the done cycle.
    @(negedge clk);
    num1 = 16'hA000; num2 = 16'h9FFF; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("b2b_first_done", 32'({done4, gto4, lto4, eqo4}), 32'b1100);
    num1 = 16'h0001; num2 = 16'h0002; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_cleared", 32'({busy4, done4, gto4, lto4, eqo4}), 32'b10000);
    lat = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (done4) begin
        lat = c;
        break;
      end
    end
    chk("b2b_second_lat", 32'(lat), 32'd4);
    chk("b2b_second_res", 32'({gto4, lto4, eqo4}), 32'b010);

    // Reset in the middle of a compare aborts it without a done.
    @(negedge clk);
    num1 = 16'h1234; num2 = 16'h1234; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_outs", 32'({busy4, done4, gto4, lto4, eqo4, st4}), 32'd0);
    dcnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done4) dcnt++;
    end
    chk("abort_no_done", 32'(dcnt), 32'd0);
    do_cmp(16'h4321, 16'h4320, 1'b1, "after_abort");

    // Let all instances drain before the shared sweep.
    repeat (20) @(negedge clk);

    // Random sweep across DIGIT = 1, 4, 16.
    for (int it = 0; it < 40; it++) begin
      logic [15:0] a, b;
      logic sm;
      int l1, l4, l16, c1, c4, c16;
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = a ^ 16'(1 << $urandom_range(0, 15));
        default: b = 16'($urandom);
      endcase
      sm = 1'($urandom_range(0, 1));
      num1 = a; num2 = b; signed_mode = sm; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      l1 = 0; l4 = 0; l16 = 0; c1 = 0; c4 = 0; c16 = 0;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        if (done1)  begin c1++;  if (l1 == 0)  l1 = c;  end
        if (done4)  begin c4++;  if (l4 == 0)  l4 = c;  end
        if (done16) begin c16++; if (l16 == 0) l16 = c; end
      end
      chk($sformatf("rnd%0d_d1_lat", it), 32'(l1), 32'(model_lat(a, b, 1)));
      chk($sformatf("rnd%0d_d4_lat", it), 32'(l4), 32'(model_lat(a, b, 4)));
      chk($sformatf("rnd%0d_d16_lat", it), 32'(l16), 32'(model_lat(a, b, 16)));
      chk($sformatf("rnd%0d_d1_res", it), 32'({gto1, lto1, eqo1}), 32'(model_res(a, b, sm)));
      chk($sformatf("rnd%0d_d4_res", it), 32'({gto4, lto4, eqo4}), 32'(model_res(a, b, sm)));
      chk($sformatf("rnd%0d_d16_res", it), 32'({gto16, lto16, eqo16}), 32'(model_res(a, b, sm)));
      chk($sformatf("rnd%0d_done_cnt", it), 32'({8'(c1), 8'(c4), 8'(c16)}), 32'h00010101);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
